// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at a time
// and holds the returned word with its PC until downstream consumes it.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        misalign_err
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]  state;
    logic [63:0] pc;
    logic        kill;

    logic accept;
    logic redir_ok;
    logic redir_bad;

    // Request is masked during reset so nothing is issued before the first real cycle.
    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= NOP_INST;
            inst_pc      <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir_bad) begin
                        state        <= S_ERR;
                        misalign_err <= 1'b1;
                    end else begin
                        if (redir_ok)
                            pc <= redirect_pc;
                        if (accept) begin
                            state <= S_WAIT;
                            kill  <= redir_ok;
                        end
                    end
                end
                S_WAIT: begin
                    if (redir_bad) begin
                        state        <= S_ERR;
                        misalign_err <= 1'b1;
                    end else if (imem_rvalid) begin
                        if (kill || redir_ok) begin
                            // Response belongs to a fetch that a redirect has overtaken.
                            kill  <= 1'b0;
                            state <= S_REQ;
                            if (redir_ok)
                                pc <= redirect_pc;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redir_ok) begin
                        pc   <= redirect_pc;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir_bad) begin
                        state        <= S_ERR;
                        misalign_err <= 1'b1;
                        inst_valid   <= 1'b0;
                        inst         <= NOP_INST;
                    end else if (redir_ok || !stall) begin
                        pc         <= redir_ok ? redirect_pc : pc + 64'd4;
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    inst_valid <= 1'b0;
                    inst       <= NOP_INST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed latency/redirect/reset scenarios, then a randomized
// run checked against an architectural-PC reference model and a hashed memory image.
module tb_inst_fetch;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign_err;

    // Directed and random memory drivers are kept apart and muxed onto the ports.
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        r_ready = 1'b0, r_rvalid = 1'b0;
    logic [31:0] r_rdata = 32'h0;
    logic        auto_mem = 1'b0;
    logic        sb_en = 1'b0;

    assign imem_ready  = auto_mem ? r_ready  : d_ready;
    assign imem_rvalid = auto_mem ? r_rvalid : d_rvalid;
    assign imem_rdata  = auto_mem ? r_rdata  : d_rdata;

    inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endfunction

    // Reference model: the PC of the next instruction the stage should deliver.
    logic [63:0] mpc = RST_PC;
    logic        merr = 1'b0;
    int          deliveries = 0;

    always @(posedge clk) begin
        if (rst) begin
            mpc  = RST_PC;
            merr = 1'b0;
        end else if (!merr) begin
            if (redirect_valid) begin
                if (redirect_pc[1:0] != 2'b00) merr = 1'b1;
                else                           mpc  = redirect_pc;
            end else if (inst_valid && !stall) begin
                mpc = mpc + 64'd4;
                if (sb_en) deliveries++;
            end
        end
    end

    // Random-latency memory: returns memword(addr) 1..3 cycles after accept.
    logic        pending = 1'b0;
    logic [63:0] paddr = 64'h0;
    int          dly = 0;

    always @(posedge clk) begin
        if (auto_mem) begin
            if (imem_rvalid)               pending = 1'b0;
            else if (pending && dly != 0)  dly--;
            if (imem_req && imem_ready) begin
                pending = 1'b1;
                paddr   = imem_addr;
                dly     = int'($urandom % 3);
            end
        end
    end

    always @(negedge clk) begin
        if (auto_mem) begin
            r_ready = ($urandom % 2) == 0;
            if (pending && dly == 0) begin
                r_rvalid = 1'b1;
                r_rdata  = memword(paddr);
            end else begin
                r_rvalid = 1'b0;
                r_rdata  = $urandom;
            end
        end
    end

    task automatic sb_check();
        chk("sb_err", 64'(misalign_err), 64'(merr));
        chk("sb_excl", 64'(imem_req & inst_valid), 64'd0);
        if (imem_req) chk("sb_addr", imem_addr, mpc);
        if (inst_valid) begin
            chk("sb_pc", inst_pc, mpc);
            chk("sb_inst", 64'(inst), 64'(memword(mpc)));
        end else begin
            chk("sb_nop", 64'(inst), 64'(NOP));
        end
    endtask

    // Starts in REQ; ends at the negedge where the word should be held.
    task automatic serve(input logic [31:0] d);
        d_ready = 1'b1;
        @(negedge clk);
        d_ready  = 1'b0;
        d_rvalid = 1'b1;
        d_rdata  = d;
        @(negedge clk);
        d_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d_ready = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'(NOP));
        chk("rst_pc", inst_pc, RST_PC);
        chk("rst_err", 64'(misalign_err), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);

        // First fetch and its latency
        rst = 1'b0; d_ready = 1'b1; #1;
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", imem_addr, RST_PC);
        @(negedge clk);
        d_ready = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00500093; #1;
        chk("wait_req", 64'(imem_req), 64'd0);
        chk("wait_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("lat_valid", 64'(inst_valid), 64'd1);
        chk("lat_inst", 64'(inst), 64'h00500093);
        chk("lat_pc", inst_pc, 64'h1000);

        // Stall for four cycles in HOLD
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(inst_valid), 64'd1);
            chk("stall_inst", 64'(inst), 64'h00500093);
            chk("stall_pc", inst_pc, 64'h1000);
            chk("stall_req", 64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("next_req", 64'(imem_req), 64'd1);
        chk("next_addr", imem_addr, 64'h1004);

        // Redirect while waiting; late response must be dropped
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("kill_wait_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        d_rvalid = 1'b1; d_rdata = 32'hDEADBEEF;
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("kill_valid", 64'(inst_valid), 64'd0);
        chk("kill_req", 64'(imem_req), 64'd1);
        chk("kill_addr", imem_addr, 64'h2000);
        serve(32'h11111111);
        chk("r2k_valid", 64'(inst_valid), 64'd1);
        chk("r2k_inst", 64'(inst), 64'h11111111);
        chk("r2k_pc", inst_pc, 64'h2000);
        @(negedge clk);
        chk("r2k_next", imem_addr, 64'h2004);

        // Redirect coinciding with accept
        d_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h3000;
        @(negedge clk);
        d_ready = 1'b0; redirect_valid = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hBAD00001;
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("racc_valid", 64'(inst_valid), 64'd0);
        chk("racc_req", 64'(imem_req), 64'd1);
        chk("racc_addr", imem_addr, 64'h3000);

        // Redirect coinciding with rvalid
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hBAD00002;
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        @(negedge clk);
        d_rvalid = 1'b0; redirect_valid = 1'b0;
        chk("rrv_valid", 64'(inst_valid), 64'd0);
        chk("rrv_req", 64'(imem_req), 64'd1);
        chk("rrv_addr", imem_addr, 64'h3000);
        serve(32'h33333333);
        chk("r3k_pc", inst_pc, 64'h3000);
        chk("r3k_inst", 64'(inst), 64'h33333333);

        // Redirect from HOLD to the top of the address space, then wrap
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("hold_drop", 64'(inst_valid), 64'd0);
        chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        serve(32'h44444444);
        chk("top_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("top_inst", 64'(inst), 64'h44444444);
        @(negedge clk);
        chk("wrap_req", 64'(imem_req), 64'd1);
        chk("wrap_addr", imem_addr, 64'h0);

        // Reset while waiting; stale response afterwards
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rw_req", 64'(imem_req), 64'd1);
        chk("rw_addr", imem_addr, RST_PC);
        d_rvalid = 1'b1; d_rdata = 32'hBAD00003;
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("stale_valid", 64'(inst_valid), 64'd0);
        chk("stale_addr", imem_addr, RST_PC);
        serve(32'h55555555);
        chk("rw_inst", 64'(inst), 64'h55555555);
        chk("rw_pc", inst_pc, RST_PC);
        @(negedge clk);

        // Misaligned redirect locks the stage until reset
        redirect_valid = 1'b1; redirect_pc = 64'h2002;
        @(negedge clk);
        redirect_valid = 1'b0; d_ready = 1'b1; d_rvalid = 1'b1; d_rdata = 32'hBAD00004;
        chk("mis_err", 64'(misalign_err), 64'd1);
        chk("mis_req", 64'(imem_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_req", 64'(imem_req), 64'd0);
            chk("err_valid", 64'(inst_valid), 64'd0);
            chk("err_sticky", 64'(misalign_err), 64'd1);
        end
        d_ready = 1'b0; d_rvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("err_clr", 64'(misalign_err), 64'd0);
        rst = 1'b0; #1;
        chk("restart_req", 64'(imem_req), 64'd1);
        chk("restart_addr", imem_addr, RST_PC);

        // Randomized run against the reference model
        sb_en = 1'b1; auto_mem = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sb_check();
            stall = ($urandom % 4) == 0;
            redirect_valid = ($urandom % 16) == 0;
            if (($urandom % 4) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | (64'($urandom % 4) << 2);
            else
                redirect_pc = 64'h4000 + (64'($urandom % 64) << 2);
        end
        redirect_valid = 1'b0; stall = 1'b0;
        chk("progress", 64'(deliveries >= 50), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
